counter_host_ctrl: RTL and testbench

- Bus-master sequencer that drives the chip-select/read/write register interface of the up/down counter peripheral.
- Writes the four counter registers in order PLR, ULR, LLR, CCR, optionally reads them back to verify, then pulses start.
- Monitors ec/err until completion and reports one status code to the system controller.

---
 rtl/counter_host_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_counter_host_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_host_ctrl.sv
// Bus-master sequencer for the up/down counter peripheral: programs PLR/ULR/LLR/CCR,
// optionally verifies them by read-back, starts the counter and reports a status code.
module counter_host_ctrl #(
  parameter int WR_PULSE    = 2,
  parameter int RD_PULSE    = 2,
  parameter bit VERIFY_EN   = 1'b1,
  parameter int START_PULSE = 1,
  parameter int TIMEOUT     = 65535
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       go_in,
  input  logic       abort_in,
  input  logic [7:0] plr_cfg_in,
  input  logic [7:0] ulr_cfg_in,
  input  logic [7:0] llr_cfg_in,
  input  logic [7:0] ccr_cfg_in,
  input  logic [7:0] rdata_in,
  input  logic       ec_in,
  input  logic       err_in,
  output logic       ncs_out,
  output logic       nwr_out,
  output logic       nrd_out,
  output logic       a0_out,
  output logic       a1_out,
  output logic [7:0] dout_out,
  output logic       start_out,
  output logic       busy_out,
  output logic       done_out,
  output logic [2:0] status_out
);

  // state     | meaning
  // S_IDLE    | waiting for go_in, bus released
  // S_PRECHK  | range check plr against [llr, ulr]
  // S_W_SETUP | address/data presented for register idx
  // S_W_STROBE| nwr low for WR_PULSE cycles
  // S_W_HOLD  | nwr high, address/data held
  // S_R_SETUP | address presented for read-back of idx
  // S_R_STROBE| nrd low for RD_PULSE cycles, rdata sampled on the last
  // S_R_HOLD  | nrd high, address held
  // S_START   | start_out high for START_PULSE cycles
  // S_WAIT    | watching err/ec with timeout
  // S_RELEASE | chip select released, done pulse, status latched
  typedef enum logic [3:0] {
    S_IDLE, S_PRECHK, S_W_SETUP, S_W_STROBE, S_W_HOLD,
    S_R_SETUP, S_R_STROBE, S_R_HOLD, S_START, S_WAIT, S_RELEASE
  } state_t;

  localparam logic [15:0] WR_LD = 16'(WR_PULSE - 1);
  localparam logic [15:0] RD_LD = 16'(RD_PULSE - 1);
  localparam logic [15:0] ST_LD = 16'(START_PULSE - 1);
  localparam logic [15:0] TO_LD = 16'(TIMEOUT - 1);

  state_t          state, nxt;
  logic [1:0]      idx, idx_nxt;
  logic [15:0]     tmr, tmr_nxt;
  logic            mism, mism_nxt;
  logic [2:0]      stat_nxt;
  logic            capture;
  logic [3:0][7:0] shadow;   // [0]=PLR [1]=ULR [2]=LLR [3]=CCR
  logic            nxt_bus, nxt_wr;

  always_comb begin
    nxt      = state;
    idx_nxt  = idx;
    tmr_nxt  = (tmr != 16'd0) ? tmr - 16'd1 : 16'd0;
    mism_nxt = mism;
    stat_nxt = 3'd0;
    capture  = 1'b0;
    case (state)
      S_IDLE: begin
        if (go_in) begin
          capture  = 1'b1;
          mism_nxt = 1'b0;
          nxt      = S_PRECHK;
        end
      end
      S_PRECHK: begin
        if ((shadow[0] < shadow[2]) || (shadow[0] > shadow[1])) begin
          stat_nxt = 3'd1;
          nxt      = S_RELEASE;
        end else begin
          idx_nxt = 2'd0;
          nxt     = S_W_SETUP;
        end
      end
      S_W_SETUP: begin
        tmr_nxt = WR_LD;
        nxt     = S_W_STROBE;
      end
      S_W_STROBE: begin
        if (tmr == 16'd0) nxt = S_W_HOLD;
      end
      S_W_HOLD: begin
        if (idx == 2'd3) begin
          idx_nxt = 2'd0;
          if (VERIFY_EN) begin
            nxt = S_R_SETUP;
          end else begin
            tmr_nxt = ST_LD;
            nxt     = S_START;
          end
        end else begin
          idx_nxt = idx + 2'd1;
          nxt     = S_W_SETUP;
        end
      end
      S_R_SETUP: begin
        tmr_nxt = RD_LD;
        nxt     = S_R_STROBE;
      end
      S_R_STROBE: begin
        if (tmr == 16'd0) begin
          if (rdata_in != shadow[idx]) mism_nxt = 1'b1;
          nxt = S_R_HOLD;
        end
      end
      S_R_HOLD: begin
        if (idx == 2'd3) begin
          idx_nxt = 2'd0;
          if (mism) begin
            stat_nxt = 3'd2;
            nxt      = S_RELEASE;
          end else begin
            tmr_nxt = ST_LD;
            nxt     = S_START;
          end
        end else begin
          idx_nxt = idx + 2'd1;
          nxt     = S_R_SETUP;
        end
      end
      S_START: begin
        if (tmr == 16'd0) begin
          tmr_nxt = TO_LD;
          nxt     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (err_in) begin
          stat_nxt = 3'd3;
          nxt      = S_RELEASE;
        end else if (ec_in) begin
          stat_nxt = 3'd0;
          nxt      = S_RELEASE;
        end else if (tmr == 16'd0) begin
          stat_nxt = 3'd4;
          nxt      = S_RELEASE;
        end
      end
      S_RELEASE: nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
    if (abort_in && (state != S_IDLE) && (state != S_RELEASE)) begin
      stat_nxt = 3'd5;
      nxt      = S_RELEASE;
    end
  end

  assign nxt_wr  = nxt inside {S_W_SETUP, S_W_STROBE, S_W_HOLD};
  assign nxt_bus = nxt_wr || (nxt inside {S_R_SETUP, S_R_STROBE, S_R_HOLD});

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      tmr        <= 16'd0;
      mism       <= 1'b0;
      shadow     <= '0;
      ncs_out    <= 1'b1;
      nwr_out    <= 1'b1;
      nrd_out    <= 1'b1;
      a0_out     <= 1'b0;
      a1_out     <= 1'b0;
      dout_out   <= 8'd0;
      start_out  <= 1'b0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      status_out <= 3'd0;
    end else begin
      state <= nxt;
      idx   <= idx_nxt;
      tmr   <= tmr_nxt;
      mism  <= mism_nxt;
      if (capture) shadow <= {ccr_cfg_in, llr_cfg_in, ulr_cfg_in, plr_cfg_in};
      ncs_out   <= (nxt == S_IDLE) || (nxt == S_RELEASE);
      nwr_out   <= (nxt != S_W_STROBE);
      nrd_out   <= (nxt != S_R_STROBE);
      a0_out    <= nxt_bus ? idx_nxt[1] : 1'b0;
      a1_out    <= nxt_bus ? idx_nxt[0] : 1'b0;
      dout_out  <= nxt_wr ? shadow[idx_nxt] : 8'd0;
      start_out <= (nxt == S_START);
      busy_out  <= (nxt != S_IDLE) && (nxt != S_RELEASE);
      done_out  <= (nxt == S_RELEASE);
      if (nxt == S_RELEASE) status_out <= stat_nxt;
    end
  end

endmodule

// File: tb/tb_counter_host_ctrl.sv
// Self-checking bench for counter_host_ctrl: table of programming runs against a
// model peripheral, write/read scoreboard, plus abort and mid-run reset sequences.
module tb_counter_host_ctrl;

  logic       clk_in = 1'b0;
  logic       reset_in, go_in, abort_in, ec_in, err_in;
  logic [7:0] plr_cfg_in, ulr_cfg_in, llr_cfg_in, ccr_cfg_in, rdata_in;
  logic       ncs_out, nwr_out, nrd_out, a0_out, a1_out, start_out, busy_out, done_out;
  logic [7:0] dout_out;
  logic [2:0] status_out;

  counter_host_ctrl #(
    .WR_PULSE(2), .RD_PULSE(2), .VERIFY_EN(1'b1), .START_PULSE(1), .TIMEOUT(100)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .go_in(go_in), .abort_in(abort_in),
    .plr_cfg_in(plr_cfg_in), .ulr_cfg_in(ulr_cfg_in), .llr_cfg_in(llr_cfg_in),
    .ccr_cfg_in(ccr_cfg_in), .rdata_in(rdata_in), .ec_in(ec_in), .err_in(err_in),
    .ncs_out(ncs_out), .nwr_out(nwr_out), .nrd_out(nrd_out), .a0_out(a0_out),
    .a1_out(a1_out), .dout_out(dout_out), .start_out(start_out), .busy_out(busy_out),
    .done_out(done_out), .status_out(status_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] plr, ulr, llr, ccr;
    bit         bad_ulr;
    int         ec_delay;   // WAIT cycles before ec_in pulse; -1 = never
    bit         err_too;
    logic [2:0] exp_status;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  int         starts = 0;
  logic [9:0] wq[$];
  logic [1:0] rq[$];
  logic [7:0] mem [4];
  bit         bad_ulr = 1'b0;
  logic       prev_nwr = 1'b1, prev_nrd = 1'b1, prev_st = 1'b0;
  vec_t       vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, int'({ncs_out, nwr_out, nrd_out, a0_out, a1_out, dout_out,
                    start_out, busy_out, done_out, status_out}),
        int'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0}));
  endtask

  task automatic push_expect(input vec_t v);
    wq.push_back({2'b00, v.plr});
    wq.push_back({2'b01, v.ulr});
    wq.push_back({2'b10, v.llr});
    wq.push_back({2'b11, v.ccr});
    for (int k = 0; k < 4; k++) rq.push_back(2'(k));
  endtask

  task automatic run_vec(input vec_t v, input bit with_abort);
    int  gc, wc, st0;
    bit  done, in_wait, pst;
    @(negedge clk_in);
    plr_cfg_in = v.plr; ulr_cfg_in = v.ulr; llr_cfg_in = v.llr; ccr_cfg_in = v.ccr;
    bad_ulr = v.bad_ulr; go_in = 1'b1; abort_in = with_abort;
    st0 = starts;
    if (v.exp_status != 3'd1) push_expect(v);
    @(negedge clk_in);
    go_in = 1'b0; abort_in = 1'b0;
    plr_cfg_in = ~v.plr; ulr_cfg_in = ~v.ulr; llr_cfg_in = ~v.llr; ccr_cfg_in = ~v.ccr;
    chk("busy_after_go", int'({busy_out, ncs_out}), 2);
    gc = 1; wc = 0; done = 1'b0; in_wait = 1'b0; pst = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (in_wait) wc++;
      else if (pst && !start_out) begin in_wait = 1'b1; wc = 0; end
      if (done_out) done = 1'b1;
      else begin
        ec_in  = in_wait && v.ec_delay >= 0 && wc == v.ec_delay;
        err_in = ec_in && v.err_too;
        go_in  = in_wait && wc == 5;
        pst = start_out;
        @(negedge clk_in);
        gc++;
      end
    end
    go_in = 1'b0; ec_in = 1'b0; err_in = 1'b0;
    chk("done_seen", int'(done), 1);
    chk("status", int'(status_out), int'(v.exp_status));
    chk("writes_left", wq.size(), 0);
    chk("reads_left", rq.size(), 0);
    chk("start_pulses", starts - st0,
        (v.exp_status == 3'd0 || v.exp_status == 3'd3 || v.exp_status == 3'd4) ? 1 : 0);
    if (v.exp_status == 3'd1) chk("prechk_latency", gc, 2);
    if (in_wait) chk("wait_cycles", wc, (v.ec_delay < 0) ? 100 : v.ec_delay + 1);
    @(negedge clk_in);
    chk("done_one_cycle", int'(done_out), 0);
    repeat (5) @(negedge clk_in);
    chk("idle_after_run", int'({busy_out, ncs_out}), 1);
    wq.delete(); rq.delete();
  endtask

  initial begin
    logic [9:0] ew;
    logic [1:0] er;
    bit         found;
    vecs[0] = '{8'd10, 8'd20, 8'd5, 8'd2, 1'b0, 50, 1'b0, 3'd0};
    vecs[1] = '{8'd30, 8'd20, 8'd5, 8'd2, 1'b0, 10, 1'b0, 3'd1};
    vecs[2] = '{8'd3, 8'd20, 8'd5, 8'd2, 1'b0, 10, 1'b0, 3'd1};
    vecs[3] = '{8'd10, 8'd20, 8'd5, 8'd2, 1'b1, 10, 1'b0, 3'd2};
    vecs[4] = '{8'd10, 8'd20, 8'd5, 8'd2, 1'b0, 7, 1'b1, 3'd3};
    vecs[5] = '{8'd10, 8'd20, 8'd5, 8'd2, 1'b0, -1, 1'b0, 3'd4};
    vecs[6] = '{8'd5, 8'd20, 8'd5, 8'd0, 1'b0, 3, 1'b0, 3'd0};
    vecs[7] = '{8'd20, 8'd20, 8'd5, 8'd9, 1'b0, 0, 1'b0, 3'd0};
    vecs[8] = '{8'hFF, 8'hFF, 8'h00, 8'h80, 1'b0, 12, 1'b0, 3'd0};
    for (int k = 0; k < 4; k++) mem[k] = 8'd0;

    reset_in = 1'b1; go_in = 1'b0; abort_in = 1'b0; ec_in = 1'b0; err_in = 1'b0;
    plr_cfg_in = 8'd0; ulr_cfg_in = 8'd0; llr_cfg_in = 8'd0; ccr_cfg_in = 8'd0;
    rdata_in = 8'd0;

    // Peripheral model plus write/read scoreboard and per-cycle protocol checks.
    fork
      forever begin
        @(negedge clk_in);
        if (!nwr_out && prev_nwr) begin
          mem[{a0_out, a1_out}] = dout_out;
          if (wq.size() == 0) chk("unexpected_write", int'({a0_out, a1_out, dout_out}), -1);
          else begin
            ew = wq.pop_front();
            chk("write_addr_data", int'({a0_out, a1_out, dout_out}), int'(ew));
          end
        end
        if (!nrd_out && prev_nrd) begin
          if (rq.size() == 0) chk("unexpected_read", int'({a0_out, a1_out}), -1);
          else begin
            er = rq.pop_front();
            chk("read_addr", int'({a0_out, a1_out}), int'(er));
          end
        end
        if (!nwr_out || !nrd_out) chk("strobe_overlap", int'(!nwr_out && !nrd_out), 0);
        if (done_out) chk("busy_with_done", int'(busy_out), 0);
        if (start_out && !prev_st) starts++;
        rdata_in = (bad_ulr && {a0_out, a1_out} == 2'b01) ? 8'h15 : mem[{a0_out, a1_out}];
        prev_nwr = nwr_out; prev_nrd = nrd_out; prev_st = start_out;
      end
    join_none

    repeat (2) @(negedge clk_in);
    chk_reset_vals("reset_values");
    reset_in = 1'b0;

    for (int t = 0; t < 9; t++) run_vec(vecs[t], 1'b0);

    // Abort during the second cycle of the ULR write strobe.
    @(negedge clk_in);
    plr_cfg_in = 8'd10; ulr_cfg_in = 8'd20; llr_cfg_in = 8'd5; ccr_cfg_in = 8'd2;
    bad_ulr = 1'b0; go_in = 1'b1;
    wq.push_back({2'b00, 8'd10});
    wq.push_back({2'b01, 8'd20});
    @(negedge clk_in);
    go_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (!nwr_out && {a0_out, a1_out} == 2'b01) found = 1'b1;
      else @(negedge clk_in);
    end
    chk("ulr_strobe_seen", int'(found), 1);
    @(negedge clk_in);
    chk("ulr_strobe_cycle2", int'(nwr_out), 0);
    abort_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("abort_release", int'({nwr_out, ncs_out, done_out, start_out}), int'(4'b1110));
    @(negedge clk_in);
    abort_in = 1'b0;
    chk("abort_status", int'(status_out), 5);
    chk("abort_writes_left", wq.size(), 0);
    wq.delete();
    run_vec(vecs[0], 1'b0);

    // abort_in in IDLE is ignored; abort with go in the same IDLE cycle accepts go.
    @(negedge clk_in);
    abort_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("abort_idle_ignored", int'({busy_out, done_out, status_out}), 0);
    run_vec(vecs[6], 1'b1);

    // Reset in the middle of a read strobe.
    @(negedge clk_in);
    plr_cfg_in = 8'd10; ulr_cfg_in = 8'd20; llr_cfg_in = 8'd5; ccr_cfg_in = 8'd2;
    go_in = 1'b1;
    push_expect(vecs[0]);
    @(negedge clk_in);
    go_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (!nrd_out) found = 1'b1;
      else @(negedge clk_in);
    end
    chk("read_strobe_seen", int'(found), 1);
    #2 reset_in = 1'b1;
    #1 chk_reset_vals("reset_mid_read");
    @(negedge clk_in);
    reset_in = 1'b0;
    wq.delete(); rq.delete();
    run_vec(vecs[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
